// File: rtl/ysyx_24100005_ifu_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_24100005_ifu_pkg
//   Shared definitions for the instruction fetch unit: datapath width, the
//   default reset PC and the fetch FSM state encoding.
// -----------------------------------------------------------------------------
package ysyx_24100005_ifu_pkg;

   localparam int unsigned IFU_XLEN = 32;

   localparam logic [IFU_XLEN-1:0] IFU_RESET_PC = 32'h8000_0000;

   // REQ   : request presented to instruction memory
   // WAIT  : request accepted, response outstanding
   // HOLD  : instruction buffered and offered to decode
   // FAULT : misaligned redirect seen; only reset leaves this state
   typedef enum logic [1:0] {
      StReq   = 2'd0,
      StWait  = 2'd1,
      StHold  = 2'd2,
      StFault = 2'd3
   } ifu_state_e;

   // Instruction addresses must be word aligned.
   function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
      return addr_lsbs == 2'b00;
   endfunction

endpackage

// File: rtl/ysyx_24100005_ifu.sv
// -----------------------------------------------------------------------------
// ysyx_24100005_ifu
//   Instruction fetch unit. Owns the architectural PC, keeps at most one
//   request outstanding to instruction memory, and hands each returned word
//   with its PC to decode over a valid/ready handshake. Execute may redirect
//   the PC at any time; a fetch already committed to memory is discarded when
//   it returns.
//
// Ports
//   clk             : clock, rising edge
//   rst             : asynchronous active-high reset
//   imem_req_valid  : fetch request valid (high in REQ only)
//   imem_req_ready  : memory accepts the request this cycle
//   imem_req_addr   : word-aligned fetch address, stable while pending
//   imem_resp_valid : one-cycle pulse carrying the fetched word
//   imem_resp_data  : fetched instruction word
//   inst_valid      : instruction offered to decode
//   inst_ready      : decode consumes the instruction this cycle
//   inst            : instruction word
//   inst_pc         : PC of inst
//   redirect_valid  : execute redirects fetch
//   redirect_pc     : redirect target
//   fetch_fault     : sticky, set by a misaligned redirect target
// -----------------------------------------------------------------------------
module ysyx_24100005_ifu
   import ysyx_24100005_ifu_pkg::*;
#(
   parameter int unsigned     XLEN     = IFU_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   // instruction memory request
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   // instruction memory response
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   // decode handshake
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   // redirect from execute
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_fault
);

   ifu_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic            drop_q, drop_d;
   logic            fault_q, fault_d;

   logic            redirect_bad;

   assign redirect_bad = redirect_valid && !is_word_aligned(redirect_pc[1:0]);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      drop_d     = drop_q;
      fault_d    = fault_q;

      if (state_q != StFault && redirect_bad) begin
         // Any outstanding response is swallowed because FAULT ignores memory.
         fault_d = 1'b1;
         state_d = StFault;
      end else begin
         unique case (state_q)
            StReq: begin
               // The address stays put while pending; the old-address fetch is
               // marked for discard and the drop path refetches from pc.
               if (redirect_valid) begin
                  pc_d   = redirect_pc;
                  drop_d = 1'b1;
               end
               if (imem_req_ready) begin
                  state_d = StWait;
               end
            end

            StWait: begin
               if (redirect_valid) begin
                  pc_d   = redirect_pc;
                  drop_d = 1'b1;
               end
               if (imem_resp_valid) begin
                  if (redirect_valid || drop_q) begin
                     drop_d     = 1'b0;
                     req_addr_d = redirect_valid ? redirect_pc : pc_q;
                     state_d    = StReq;
                  end else begin
                     inst_d    = imem_resp_data;
                     inst_pc_d = req_addr_q;
                     state_d   = StHold;
                  end
               end
            end

            StHold: begin
               // Redirect kills the held instruction even if decode is ready.
               if (redirect_valid) begin
                  pc_d       = redirect_pc;
                  req_addr_d = redirect_pc;
                  state_d    = StReq;
               end else if (inst_ready) begin
                  pc_d       = pc_q + XLEN'(4);
                  req_addr_d = pc_q + XLEN'(4);
                  state_d    = StReq;
               end
            end

            StFault: begin
               state_d = StFault;
            end

            default: begin
               state_d = StFault;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StReq;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         inst_q     <= '0;
         inst_pc_q  <= '0;
         drop_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
         drop_q     <= drop_d;
         fault_q    <= fault_d;
      end
   end

   assign imem_req_valid = (state_q == StReq);
   assign imem_req_addr  = req_addr_q;
   assign inst_valid     = (state_q == StHold);
   assign inst           = inst_q;
   assign inst_pc        = inst_pc_q;
   assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// -----------------------------------------------------------------------------
// tb_ysyx_24100005_ifu
//   Directed bench for the instruction fetch unit. Memory and decode are
//   driven by hand; inputs change and outputs are sampled 1 time unit after
//   the rising edge.
// -----------------------------------------------------------------------------
module tb_ysyx_24100005_ifu;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   int checks;
   int errors;

   ysyx_24100005_ifu dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .fetch_fault     (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept the pending request, then return one response word.
   task automatic fetch(input logic [31:0] data);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = data;
      tick();
      imem_resp_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
         errors++;
         $display("FAIL reset_req got valid=%0b addr=%h exp valid=1 addr=80000000",
                  imem_req_valid, imem_req_addr);
      end
      checks++;
      if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || fetch_fault !== 1'b0)
      begin
         errors++;
         $display("FAIL reset_out got iv=%0b inst=%h pc=%h ff=%0b exp 0/0/0/0",
                  inst_valid, inst, inst_pc, fetch_fault);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_basic();
      imem_req_ready = 1'b1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
         errors++;
         $display("FAIL basic_req got valid=%0b addr=%h exp 1/80000000",
                  imem_req_valid, imem_req_addr);
      end
      tick();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h0000_0413;
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_wait got req_valid=%0b inst_valid=%0b exp 0/0",
                  imem_req_valid, inst_valid);
      end
      tick();
      imem_resp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 32'h8000_0000) begin
         errors++;
         $display("FAIL basic_inst got iv=%0b inst=%h pc=%h exp 1/00000413/80000000",
                  inst_valid, inst, inst_pc);
      end
   endtask

   task automatic test_stall();
      inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 32'h8000_0000 ||
             imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d] got iv=%0b inst=%h pc=%h rv=%0b exp 1/413/80000000/0",
                     i, inst_valid, inst, inst_pc, imem_req_valid);
         end
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004)
      begin
         errors++;
         $display("FAIL stall_next got iv=%0b rv=%0b addr=%h exp 0/1/80000004",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_redirect_wait();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0100;
      tick();
      redirect_valid  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_BEEF;
      tick();
      imem_resp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100)
      begin
         errors++;
         $display("FAIL rw_drop got iv=%0b rv=%0b addr=%h exp 0/1/80000100",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
      fetch(32'h0010_0093);
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0100) begin
         errors++;
         $display("FAIL rw_refetch got iv=%0b inst=%h pc=%h exp 1/00100093/80000100",
                  inst_valid, inst, inst_pc);
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      // Two redirects while waiting: the later one wins.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      tick();
      redirect_pc = 32'h8000_0300;
      tick();
      redirect_valid  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h1234_5678;
      tick();
      imem_resp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300)
      begin
         errors++;
         $display("FAIL b2b_latest got iv=%0b rv=%0b addr=%h exp 0/1/80000300",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
      // Redirect coincident with the response.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready  = 1'b0;
      redirect_valid  = 1'b1;
      redirect_pc     = 32'h8000_0400;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hAAAA_5555;
      tick();
      redirect_valid  = 1'b0;
      imem_resp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0400)
      begin
         errors++;
         $display("FAIL b2b_coincident got iv=%0b rv=%0b addr=%h exp 0/1/80000400",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_redirect_req();
      rst = 1'b1;
      tick();
      rst            = 1'b0;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0100;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL rq_stable[%0d] got rv=%0b addr=%h exp 1/80000000",
                     i, imem_req_valid, imem_req_addr);
         end
         tick();
         redirect_valid = 1'b0;
      end
      fetch(32'h1111_1111);
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100)
      begin
         errors++;
         $display("FAIL rq_drop got iv=%0b rv=%0b addr=%h exp 0/1/80000100",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
      fetch(32'h0020_0113);
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0020_0113 || inst_pc !== 32'h8000_0100) begin
         errors++;
         $display("FAIL rq_refetch got iv=%0b inst=%h pc=%h exp 1/00200113/80000100",
                  inst_valid, inst, inst_pc);
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
   endtask

   task automatic test_hold_redirect_wrap();
      fetch(32'h0030_0193);
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC)
      begin
         errors++;
         $display("FAIL hold_kill got iv=%0b rv=%0b addr=%h exp 0/1/fffffffc",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
      fetch(32'h0000_0013);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_inst got iv=%0b pc=%h exp 1/fffffffc", inst_valid, inst_pc);
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
         errors++;
         $display("FAIL wrap_addr got rv=%0b addr=%h exp 1/00000000",
                  imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_reset_mid_wait();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || inst_valid !== 1'b0 ||
          inst !== 32'h0 || inst_pc !== 32'h0 || fetch_fault !== 1'b0) begin
         errors++;
         $display("FAIL rst_async got rv=%0b addr=%h iv=%0b inst=%h pc=%h ff=%0b exp 1/80000000/0/0/0/0",
                  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault);
      end
      tick();
      rst = 1'b0;
      // Stray response outside WAIT must be ignored.
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hBAD0_BAD0;
      tick();
      imem_resp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000)
      begin
         errors++;
         $display("FAIL rst_stray got iv=%0b rv=%0b addr=%h exp 0/1/80000000",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
      fetch(32'h0000_0513);
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0000_0513 || inst_pc !== 32'h8000_0000) begin
         errors++;
         $display("FAIL rst_refetch got iv=%0b inst=%h pc=%h exp 1/00000513/80000000",
                  inst_valid, inst, inst_pc);
      end
   endtask

   task automatic test_fault();
      inst_ready = 1'b1;
      tick();
      inst_ready     = 1'b0;
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0102;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL fault_set got ff=%0b rv=%0b iv=%0b exp 1/0/0",
                  fetch_fault, imem_req_valid, inst_valid);
      end
      // Late response, ready memory, decode and an aligned redirect: all ignored.
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h0040_0213;
      imem_req_ready  = 1'b1;
      inst_ready      = 1'b1;
      redirect_valid  = 1'b1;
      redirect_pc     = 32'h8000_0200;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_stuck[%0d] got ff=%0b rv=%0b iv=%0b exp 1/0/0",
                     i, fetch_fault, imem_req_valid, inst_valid);
         end
      end
      imem_resp_valid = 1'b0;
      imem_req_ready  = 1'b0;
      inst_ready      = 1'b0;
      redirect_valid  = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000)
      begin
         errors++;
         $display("FAIL fault_clear got ff=%0b rv=%0b addr=%h exp 0/1/80000000",
                  fetch_fault, imem_req_valid, imem_req_addr);
      end
      tick();
      rst = 1'b0;
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      rst             = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      inst_ready      = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'h0;
      #1;
      rst = 1'b1;

      test_reset();
      test_basic();
      test_stall();
      test_redirect_wait();
      test_back_to_back();
      test_redirect_req();
      test_hold_redirect_wrap();
      test_reset_mid_wait();
      test_fault();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
